// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive side of the four-digit multiplexed seven-segment
// display. Registers the scanned anode/segment bus, filters each slot for
// stability, decodes active-low segment patterns to BCD and republishes
// complete MM:SS frames with error reporting.
module seg_scan_decoder #(
   parameter int unsigned STABLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] anode,
   input  logic [6:0] segments,
   output logic [3:0] minutes_tens,
   output logic [3:0] minutes_units,
   output logic [3:0] seconds_tens,
   output logic [3:0] seconds_units,
   output logic       frame_valid,
   output logic       locked,
   output logic       anode_err,
   output logic       seq_err,
   output logic       seg_err
);

   localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

   typedef enum logic [1:0] {HUNT, GOT0, GOT1, GOT2} state_t;

   state_t      state_q, state_d;

   logic [3:0]  anode_q, anode_d;
   logic [6:0]  seg_q, seg_d;
   logic [3:0]  run_q, run_d;
   logic        hit_q, hit_d;
   logic        same;

   logic        bad_q, bad_d;
   logic [3:0]  su_p_q, su_p_d;
   logic [3:0]  st_p_q, st_p_d;
   logic [3:0]  mu_p_q, mu_p_d;
   logic [3:0]  mt_q, mt_d;
   logic [3:0]  mu_q, mu_d;
   logic [3:0]  st_q, st_d;
   logic [3:0]  su_q, su_d;
   logic        fv_q, fv_d;
   logic        lock_q, lock_d;
   logic        aerr_q, aerr_d;
   logic        qerr_q, qerr_d;
   logic        serr_q, serr_d;

   logic        blank, multi;
   logic        slot0, slot1, slot2, slot3;
   logic        dig_ok;
   logic [3:0]  dig;

   // Input capture and run counter; hit marks the single accepting capture of a run
   always_comb begin
      anode_d = anode;
      seg_d   = segments;
      same    = ({anode, segments} == {anode_q, seg_q}) && (run_q != '0);
      if (same) begin
         run_d = (run_q == STABLE) ? STABLE : run_q + 4'd1;
      end else begin
         run_d = 4'd1;
      end
      // a saturated run repeating itself must not accept again
      hit_d = (run_d == STABLE) && !(same && (run_q == STABLE));
   end

   // Input stage registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         anode_q <= '1;
         seg_q   <= '1;
         run_q   <= '0;
         hit_q   <= 1'b0;
      end else begin
         anode_q <= anode_d;
         seg_q   <= seg_d;
         run_q   <= run_d;
         hit_q   <= hit_d;
      end
   end

   // Slot classification and segment decode of the accepted sample
   always_comb begin
      slot0  = 1'b0;
      slot1  = 1'b0;
      slot2  = 1'b0;
      slot3  = 1'b0;
      blank  = 1'b0;
      multi  = 1'b0;
      case (anode_q)
         4'b1110: slot0 = 1'b1;
         4'b1101: slot1 = 1'b1;
         4'b1011: slot2 = 1'b1;
         4'b0111: slot3 = 1'b1;
         4'b1111: blank = 1'b1;
         default: multi = 1'b1;
      endcase
      dig_ok = 1'b1;
      dig    = '0;
      case (seg_q)
         7'b1000000: dig = 4'd0;
         7'b1111001: dig = 4'd1;
         7'b0100100: dig = 4'd2;
         7'b0110000: dig = 4'd3;
         7'b0011001: dig = 4'd4;
         7'b0010010: dig = 4'd5;
         7'b0000010: dig = 4'd6;
         7'b1111000: dig = 4'd7;
         7'b0000000: dig = 4'd8;
         7'b0010000: dig = 4'd9;
         default:    dig_ok = 1'b0;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: advance on the expected slot, restart on 1110, else hunt
   always_comb begin
      state_d = state_q;
      if (hit_q && !blank) begin
         if (multi) begin
            state_d = HUNT;
         end else begin
            case (state_q)
               HUNT: if (slot0) state_d = GOT0;
               GOT0: state_d = slot1 ? GOT1 : (slot0 ? GOT0 : HUNT);
               GOT1: state_d = slot2 ? GOT2 : (slot0 ? GOT0 : HUNT);
               GOT2: state_d = slot3 ? HUNT : (slot0 ? GOT0 : HUNT);
               default: state_d = HUNT;
            endcase
         end
      end
   end

   // FSM outputs: partial digits, bad-frame flag, publication and error pulses
   always_comb begin
      bad_d  = bad_q;
      su_p_d = su_p_q;
      st_p_d = st_p_q;
      mu_p_d = mu_p_q;
      mt_d   = mt_q;
      mu_d   = mu_q;
      st_d   = st_q;
      su_d   = su_q;
      fv_d   = 1'b0;
      lock_d = lock_q;
      aerr_d = 1'b0;
      qerr_d = 1'b0;
      serr_d = 1'b0;
      if (hit_q && !blank) begin
         if (multi) begin
            aerr_d = 1'b1;
            lock_d = 1'b0;
         end else begin
            serr_d = !dig_ok;
            if (state_q == HUNT) begin
               if (slot0) begin
                  su_p_d = dig;
                  bad_d  = !dig_ok;
               end
            end else if ((state_q == GOT0 && slot1) || (state_q == GOT1 && slot2)) begin
               if (slot1) st_p_d = dig;
               if (slot2) mu_p_d = dig;
               bad_d = bad_q || !dig_ok;
            end else if (state_q == GOT2 && slot3) begin
               if (bad_q || !dig_ok) begin
                  lock_d = 1'b0;
               end else begin
                  mt_d   = dig;
                  mu_d   = mu_p_q;
                  st_d   = st_p_q;
                  su_d   = su_p_q;
                  fv_d   = 1'b1;
                  lock_d = 1'b1;
               end
            end else begin
               qerr_d = 1'b1;
               if (slot0) begin
                  su_p_d = dig;
                  bad_d  = !dig_ok;
               end
            end
            if (qerr_d || serr_d) lock_d = 1'b0;
         end
      end
   end

   // Datapath and status registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bad_q  <= 1'b0;
         su_p_q <= '0;
         st_p_q <= '0;
         mu_p_q <= '0;
         mt_q   <= '0;
         mu_q   <= '0;
         st_q   <= '0;
         su_q   <= '0;
         fv_q   <= 1'b0;
         lock_q <= 1'b0;
         aerr_q <= 1'b0;
         qerr_q <= 1'b0;
         serr_q <= 1'b0;
      end else begin
         bad_q  <= bad_d;
         su_p_q <= su_p_d;
         st_p_q <= st_p_d;
         mu_p_q <= mu_p_d;
         mt_q   <= mt_d;
         mu_q   <= mu_d;
         st_q   <= st_d;
         su_q   <= su_d;
         fv_q   <= fv_d;
         lock_q <= lock_d;
         aerr_q <= aerr_d;
         qerr_q <= qerr_d;
         serr_q <= serr_d;
      end
   end

   assign minutes_tens  = mt_q;
   assign minutes_units = mu_q;
   assign seconds_tens  = st_q;
   assign seconds_units = su_q;
   assign frame_valid   = fv_q;
   assign locked        = lock_q;
   assign anode_err     = aerr_q;
   assign seq_err       = qerr_q;
   assign seg_err       = serr_q;

endmodule
